nco_phase_gen: RTL

- Upstream stage of sincos_pipelined. Generates the signed 12-bit binary-angle stream that drives its Angle input, one sample per Clock.
- Supports a fixed-frequency mode and a linear-chirp sweep mode.
- Delays a valid/last tag by the Angle-to-Sin/Cos latency so consumers can qualify Sin/Cos without counting cycles.

---
 rtl/nco_pkg.sv | 25 ++
 rtl/nco_phase_gen_tag_delay_line.sv | 26 ++
 rtl/nco_phase_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared types and defaults for the NCO phase generator feeding sincos_pipelined.
package nco_pkg;

  localparam int unsigned ACC_W_DEF      = 24;
  localparam int unsigned ANGLE_W_DEF    = 12;
  localparam int unsigned CORDIC_LAT_DEF = 13;

  // Binary-angle landmarks for a 12-bit angle.
  localparam logic [11:0] ANGLE_ZERO    = 12'h000;
  localparam logic [11:0] ANGLE_HALF_PI = 12'h400;
  localparam logic [11:0] ANGLE_PI      = 12'h800;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SWEEP,
    FLUSH
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/nco_phase_gen_tag_delay_line.sv
// Delays the (valid, last) sample tag so it lines up with the CORDIC Sin/Cos outputs.
module tag_delay_line
  import nco_pkg::*;
#(
  parameter int unsigned DEPTH = CORDIC_LAT_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] stages;

  // New tag enters at index 0; the oldest falls off the top.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stages <= '0;
    end else begin
      stages <= $bits(stages)'({stages, tag_in});
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO with fixed and linear-chirp modes, producing the binary angle
// stream for sincos_pipelined plus a latency-matched valid/last tag.
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned ANGLE_W    = ANGLE_W_DEF,
  parameter int unsigned CORDIC_LAT = CORDIC_LAT_DEF
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      cfg_mode,
  input  logic [ACC_W-1:0]          cfg_ftw,
  input  logic [ACC_W-1:0]          cfg_step,
  input  logic [ACC_W-1:0]          cfg_ftw_stop,
  input  logic [ANGLE_W-1:0]        cfg_phase_off,
  input  logic                      start,
  input  logic                      stop,
  output logic signed [ANGLE_W-1:0] Angle,
  output logic                      angle_valid,
  output logic                      busy,
  output logic                      sample_valid_out,
  output logic                      sample_last_out,
  output logic                      done
);

  localparam int unsigned CNT_W = $clog2(CORDIC_LAT + 1);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   ftw_cur;
  logic               mode_reg;
  logic [ACC_W-1:0]   ftw_reg;
  logic [ACC_W-1:0]   step_reg;
  logic [ACC_W-1:0]   ftw_stop_reg;
  logic [ANGLE_W-1:0] phase_off_reg;
  logic [CNT_W-1:0]   flush_cnt;
  logic               angle_last;

  logic [ACC_W:0]     sweep_sum_c;
  logic               sweep_end_c;
  logic [ANGLE_W-1:0] angle_next_c;
  tag_t               tag_in;
  tag_t               tag_out;

  // Sweep ends once the next tuning word would pass the stop word; a zero step never ends it.
  assign sweep_sum_c  = {1'b0, ftw_cur} + {1'b0, step_reg};
  assign sweep_end_c  = (step_reg != '0) && (sweep_sum_c > {1'b0, ftw_stop_reg});
  assign angle_next_c = acc[ACC_W-1 -: ANGLE_W] + phase_off_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      acc           <= '0;
      ftw_cur       <= '0;
      mode_reg      <= 1'b0;
      ftw_reg       <= '0;
      step_reg      <= '0;
      ftw_stop_reg  <= '0;
      phase_off_reg <= '0;
      flush_cnt     <= '0;
      Angle         <= ANGLE_W'(ANGLE_ZERO);
      angle_valid   <= 1'b0;
      angle_last    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_ready     <= 1'b1;
    end else begin
      done        <= 1'b0;
      angle_valid <= 1'b0;
      angle_last  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_valid) begin
            mode_reg      <= cfg_mode;
            ftw_reg       <= cfg_ftw;
            step_reg      <= cfg_step;
            ftw_stop_reg  <= cfg_ftw_stop;
            phase_off_reg <= cfg_phase_off;
          end
          // A config offered alongside start takes effect for that start.
          if (start) begin
            state     <= (cfg_valid ? cfg_mode : mode_reg) ? SWEEP : RUN;
            acc       <= '0;
            ftw_cur   <= cfg_valid ? cfg_ftw : ftw_reg;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN, SWEEP: begin
          Angle       <= angle_next_c;
          angle_valid <= 1'b1;
          acc         <= acc + ftw_cur;
          if (state == SWEEP) begin
            ftw_cur <= ftw_cur + step_reg;
          end
          if (stop || ((state == SWEEP) && sweep_end_c)) begin
            angle_last <= 1'b1;
            state      <= FLUSH;
            flush_cnt  <= '0;
          end
        end
        FLUSH: begin
          // Hold off done until the last tag has emerged from the delay line.
          if (flush_cnt == CNT_W'(CORDIC_LAT)) begin
            done      <= 1'b1;
            state     <= IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tag_in = '{valid: angle_valid, last: angle_last};

  tag_delay_line #(
    .DEPTH(CORDIC_LAT)
  ) u_tag_delay (
    .Clock  (Clock),
    .Reset  (Reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign sample_valid_out = tag_out.valid;
  assign sample_last_out  = tag_out.last;

endmodule
